data_memory_sized: RTL and testbench

Byte-addressed, big-endian data memory for the single-cycle/multi-cycle CPU datapath. It generalises the fixed 44-byte word memory in three ways: parametrised depth, byte/half/word accesses with sign or zero extension, and alignment and range error flagging. A multi-cycle preload sweep, triggered by startin, replaces the one-shot preload. Reads are registered, and a busy/valid handshake is exposed to the control unit.

---
 rtl/data_memory_sized_if.sv | 29 ++
 rtl/data_memory_sized.sv | 171 +++++++++++++++++
 tb/tb_data_memory_sized.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_sized_if.sv
// Bus between the control unit and data_memory_sized: preload trigger,
// access request and the registered load/error responses.
interface data_memory_sized_if #(
  parameter int ADDR_W = 32
);
  logic              startin;
  logic              busy;
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              rvalid;
  logic              err;

  // Control unit side
  modport master (
    output startin, req, we, size, unsigned_ld, addr, wdata,
    input  busy, rdata, rvalid, err
  );

  // Memory side
  modport slave (
    input  startin, req, we, size, unsigned_ld, addr, wdata,
    output busy, rdata, rvalid, err
  );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory with byte/half/word accesses,
// sign/zero extension on loads, alignment/range error pulses and a
// multi-cycle preload sweep. Storage is split into four byte lanes so each
// lane maps onto a plain RAM with its own write enable.
module data_memory_sized #(
  parameter int DEPTH_WORDS  = 16,
  parameter int ADDR_W       = 32,
  parameter int INIT_PATTERN = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  data_memory_sized_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic {ST_IDLE, ST_INIT} state_t;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_cnt, w_cnt_next;

  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_err;

  logic              w_idle, w_accept, w_aligned, w_in_range, w_legal;
  logic              w_store, w_load, w_init_we;
  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_word_idx;
  logic [IDX_W-1:0]  w_addr_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata_rep, w_init_word, w_rd_word, w_load_val;
  logic [7:0]        w_rd_byte;
  logic [15:0]       w_rd_half;

  // State register and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: sweep every word once, leaving on the last write
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.startin) begin
          w_state_next = ST_INIT;
          w_cnt_next   = '0;
        end
      end
      ST_INIT: begin
        if (r_cnt == LAST_IDX) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + IDX_W'(1);
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign bus.busy  = (r_state == ST_INIT);
  assign w_init_we = (r_state == ST_INIT);
  assign w_idle    = (r_state == ST_IDLE);

  // startin has priority over a request in the same cycle
  assign w_accept = bus.req & w_idle & ~bus.startin;

  // Aligned accesses never straddle a word, so the range test reduces to
  // a word-index compare that cannot overflow the address width.
  assign w_off      = bus.addr[1:0];
  assign w_word_idx = {2'b00, bus.addr[ADDR_W-1:2]};
  assign w_in_range = (w_word_idx < DEPTH_A);
  assign w_addr_idx = bus.addr[IDX_W+1:2];

  // Alignment check and big-endian lane enables (lane 3 = byte at offset 0)
  always_comb begin
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    case (bus.size)
      2'b00: begin
        w_aligned           = 1'b1;
        w_be[2'd3 - w_off]  = 1'b1;
      end
      2'b01: begin
        w_aligned = ~bus.addr[0];
        w_be      = bus.addr[1] ? 4'b0011 : 4'b1100;
      end
      2'b10: begin
        w_aligned = (w_off == 2'b00);
        w_be      = 4'b1111;
      end
      default: begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
      end
    endcase
  end

  assign w_legal = w_aligned & w_in_range;
  assign w_store = w_accept & w_legal & bus.we;
  assign w_load  = w_accept & w_legal & ~bus.we;

  assign w_wdata_rep = (bus.size == 2'b00) ? {4{bus.wdata[7:0]}} :
                       (bus.size == 2'b01) ? {2{bus.wdata[15:0]}} : bus.wdata;

  assign w_init_word = (INIT_PATTERN != 0 && r_cnt != LAST_IDX) ?
                       32'(r_cnt) + 32'd1 : 32'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [DEPTH_WORDS];

      // Lane write: sweep has the port while busy, otherwise legal stores
      always_ff @(posedge clk) begin
        if (w_init_we) begin
          r_lane[r_cnt] <= w_init_word[8*gi +: 8];
        end else if (w_store && w_be[gi]) begin
          r_lane[w_addr_idx] <= w_wdata_rep[8*gi +: 8];
        end
      end

      assign w_rd_word[8*gi +: 8] = r_lane[w_addr_idx];
    end
  endgenerate

  // Offset 0 is the top byte, so the lane start is (3 - offset) * 8
  assign w_rd_byte = w_rd_word[{~w_off, 3'b000} +: 8];
  assign w_rd_half = bus.addr[1] ? w_rd_word[15:0] : w_rd_word[31:16];

  // Load extension by access size
  always_comb begin
    w_load_val = w_rd_word;
    case (bus.size)
      2'b00: w_load_val = bus.unsigned_ld ? {24'd0, w_rd_byte}
                                          : {{24{w_rd_byte[7]}}, w_rd_byte};
      2'b01: w_load_val = bus.unsigned_ld ? {16'd0, w_rd_half}
                                          : {{16{w_rd_half[15]}}, w_rd_half};
      default: w_load_val = w_rd_word;
    endcase
  end

  // Registered response: rdata only moves on a legal load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_load;
      r_err    <= w_accept & ~w_legal;
      if (w_load) begin
        r_rdata <= w_load_val;
      end
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.err    = r_err;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized (DEPTH_WORDS=16, INIT_PATTERN=1).
module tb_data_memory_sized;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   busy_cnt;

  data_memory_sized_if #(.ADDR_W(32)) u_if ();

  data_memory_sized #(
    .DEPTH_WORDS (16),
    .ADDR_W      (32),
    .INIT_PATTERN(1)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request cycle; returns #1 after the accepting edge
  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] d);
    u_if.req         = 1'b1;
    u_if.we          = w;
    u_if.size        = sz;
    u_if.unsigned_ld = uns;
    u_if.addr        = a;
    u_if.wdata       = d;
    @(posedge clk);
    #1;
    u_if.req = 1'b0;
    $display("req we=%0b size=%0d uns=%0b addr=%h wdata=%h -> rdata=%h rvalid=%0b err=%0b busy=%0b",
             w, sz, uns, a, d, u_if.rdata, u_if.rvalid, u_if.err, u_if.busy);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_load(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] exp);
    do_req(1'b0, sz, uns, a, 32'd0);
    check({tag, " rvalid"}, {31'd0, u_if.rvalid}, 32'd1);
    check({tag, " err"},    {31'd0, u_if.err},    32'd0);
    check({tag, " rdata"},  u_if.rdata, exp);
  endtask

  task automatic chk_store(input string tag, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
    do_req(1'b1, sz, 1'b0, a, d);
    check({tag, " rvalid"}, {31'd0, u_if.rvalid}, 32'd0);
    check({tag, " err"},    {31'd0, u_if.err},    32'd0);
  endtask

  task automatic chk_bad(input string tag, input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] exp_rdata);
    do_req(w, sz, 1'b0, a, 32'h0000FFFF);
    check({tag, " err"},    {31'd0, u_if.err},    32'd1);
    check({tag, " rvalid"}, {31'd0, u_if.rvalid}, 32'd0);
    check({tag, " rdata"},  u_if.rdata, exp_rdata);
    idle_cycle();
    check({tag, " err pulse"}, {31'd0, u_if.err}, 32'd0);
  endtask

  task automatic start_sweep();
    u_if.startin = 1'b1;
    @(posedge clk);
    #1;
    u_if.startin = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n;
    n = 0;
    while (u_if.busy && n < 40) begin
      n++;
      idle_cycle();
    end
    check({tag, " sweep ends"}, {31'd0, u_if.busy}, 32'd0);
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    rst_n            = 1'b0;
    u_if.startin     = 1'b0;
    u_if.req         = 1'b0;
    u_if.we          = 1'b0;
    u_if.size        = 2'b00;
    u_if.unsigned_ld = 1'b0;
    u_if.addr        = 32'd0;
    u_if.wdata       = 32'd0;

    #22;
    check("reset busy",   {31'd0, u_if.busy},   32'd0);
    check("reset rvalid", {31'd0, u_if.rvalid}, 32'd0);
    check("reset err",    {31'd0, u_if.err},    32'd0);
    check("reset rdata",  u_if.rdata,           32'd0);
    rst_n = 1'b1;
    idle_cycle();

    // Preload sweep length
    start_sweep();
    busy_cnt = 0;
    while (u_if.busy && busy_cnt < 40) begin
      busy_cnt++;
      idle_cycle();
    end
    check("busy cycles", busy_cnt, 32'd16);

    chk_load("ld w 0x00", 2'b10, 1'b0, 32'h00, 32'h00000001);
    chk_load("ld w 0x24", 2'b10, 1'b0, 32'h24, 32'h0000000A);
    chk_load("ld w 0x3C", 2'b10, 1'b0, 32'h3C, 32'h00000000);
    idle_cycle();
    check("rvalid pulse", {31'd0, u_if.rvalid}, 32'd0);

    // Sub-word loads with extension
    chk_store("st w 0x10", 2'b10, 32'h10, 32'h80FF7F01);
    chk_load("ld b 0x10 s", 2'b00, 1'b0, 32'h10, 32'hFFFFFF80);
    chk_load("ld b 0x10 u", 2'b00, 1'b1, 32'h10, 32'h00000080);
    chk_load("ld h 0x12 s", 2'b01, 1'b0, 32'h12, 32'h00007F01);
    chk_load("ld h 0x10 s", 2'b01, 1'b0, 32'h10, 32'hFFFF80FF);
    chk_load("ld h 0x10 u", 2'b01, 1'b1, 32'h10, 32'h000080FF);
    chk_load("ld b 0x13 s", 2'b00, 1'b0, 32'h13, 32'h00000001);

    // Byte store into preloaded word
    chk_store("st b 0x05", 2'b00, 32'h05, 32'h000000AB);
    chk_load("ld w 0x04", 2'b10, 1'b0, 32'h04, 32'h00AB0002);

    // Rejected requests
    chk_bad("bad w ld 0x02",   1'b0, 2'b10, 32'h02,       32'h00AB0002);
    chk_bad("bad h st 0x07",   1'b1, 2'b01, 32'h07,       32'h00AB0002);
    chk_bad("bad size 11",     1'b0, 2'b11, 32'h00,       32'h00AB0002);
    chk_bad("bad w ld 0x40",   1'b0, 2'b10, 32'h40,       32'h00AB0002);
    chk_bad("bad w ld top",    1'b0, 2'b10, 32'hFFFFFFFC, 32'h00AB0002);
    chk_bad("bad w st 0x40",   1'b1, 2'b10, 32'h40,       32'h00AB0002);
    chk_bad("bad b st 0x40",   1'b1, 2'b00, 32'h40,       32'h00AB0002);
    chk_load("ld w 0x04 kept", 2'b10, 1'b0, 32'h04, 32'h00AB0002);
    chk_load("ld w 0x00 nowrap", 2'b10, 1'b0, 32'h00, 32'h00000001);

    // Store then immediate load
    chk_store("st w 0x08", 2'b10, 32'h08, 32'h12345678);
    chk_load("ld w 0x08 raw", 2'b10, 1'b0, 32'h08, 32'h12345678);

    // Four back-to-back loads
    chk_load("b2b 0", 2'b10, 1'b0, 32'h00, 32'h00000001);
    chk_load("b2b 1", 2'b10, 1'b0, 32'h04, 32'h00AB0002);
    chk_load("b2b 2", 2'b10, 1'b0, 32'h08, 32'h12345678);
    chk_load("b2b 3", 2'b10, 1'b0, 32'h0C, 32'h00000004);

    // startin and req together, then requests during the sweep
    u_if.startin = 1'b1;
    do_req(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0);
    u_if.startin = 1'b0;
    check("start+req rvalid", {31'd0, u_if.rvalid}, 32'd0);
    check("start+req busy",   {31'd0, u_if.busy},   32'd1);
    do_req(1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
    check("busy ld rvalid", {31'd0, u_if.rvalid}, 32'd0);
    check("busy ld rdata",  u_if.rdata, 32'h00000004);
    do_req(1'b0, 2'b11, 1'b0, 32'h01, 32'd0);
    check("busy bad err", {31'd0, u_if.err}, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 32'h00, 32'hDEADBEEF);
    wait_not_busy("resweep");
    idle_cycle();
    check("resweep err", {31'd0, u_if.err}, 32'd0);
    chk_load("ld w 0x00 after", 2'b10, 1'b0, 32'h00, 32'h00000001);
    chk_load("ld w 0x08 after", 2'b10, 1'b0, 32'h08, 32'h00000003);
    chk_load("ld w 0x10 after", 2'b10, 1'b0, 32'h10, 32'h00000005);

    // Asynchronous reset in the middle of a sweep
    start_sweep();
    for (int i = 0; i < 4; i++) idle_cycle();
    check("mid sweep busy", {31'd0, u_if.busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy",   {31'd0, u_if.busy},   32'd0);
    check("async rst rvalid", {31'd0, u_if.rvalid}, 32'd0);
    check("async rst rdata",  u_if.rdata,           32'd0);
    #1;
    rst_n = 1'b1;
    idle_cycle();
    check("sweep aborted", {31'd0, u_if.busy}, 32'd0);
    chk_load("ld w 0x00 post", 2'b10, 1'b0, 32'h00, 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end
endmodule
